// File: rtl/seg_scan_pkg.sv
// Shared types for the multiplexed 8-digit segment scanner.
// Optional feature macro used by this slice: SEG_SCAN_BRIGHTNESS_EN.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [7:0] seg_pat_t;

  typedef enum logic [1:0] {
    SLOT_BLANK,
    SLOT_DRIVE,
    SLOT_OFF
  } slot_state_t;

  // Phase of a slot for a given tick position and drive-window length.
  function automatic slot_state_t slot_decode(input int unsigned tick,
                                              input int unsigned blank,
                                              input int unsigned on);
    if (tick < blank) begin
      return SLOT_BLANK;
    end else if (tick < blank + on) begin
      return SLOT_DRIVE;
    end else begin
      return SLOT_OFF;
    end
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot tick counter and digit index for the segment scanner.
// tick runs 0..DIGIT_TICKS-1; idx advances on every tick wrap.
module seg_scan_timer #(
  parameter int DIGIT_TICKS = 50000,
  parameter int TICK_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slot_wrap,
  output logic              frame_wrap,
  output logic [TICK_W-1:0] tick,
  output logic [2:0]        idx
);

  logic [TICK_W-1:0] tick_reg;
  logic [TICK_W-1:0] tick_next;
  logic [2:0]        idx_reg;
  logic [2:0]        idx_next;

  always_comb begin
    slot_wrap  = (tick_reg == TICK_W'(DIGIT_TICKS - 1));
    frame_wrap = slot_wrap && (idx_reg == 3'd7);
    tick_next  = slot_wrap ? '0 : tick_reg + TICK_W'(1);
    idx_next   = slot_wrap ? idx_reg + 3'd1 : idx_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
      idx_reg  <= '0;
    end else begin
      tick_reg <= tick_next;
      idx_reg  <= idx_next;
    end
  end

  assign tick = tick_reg;
  assign idx  = idx_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes eight latched segment patterns onto one bus with one-hot digit enables.
// Define SEG_SCAN_BRIGHTNESS_EN to add the bright port and a scaled drive window.
module seg_scan_driver #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_a,
  input  logic [7:0] led_b,
  input  logic [7:0] led_c,
  input  logic [7:0] led_d,
  input  logic [7:0] led_e,
  input  logic [7:0] led_f,
  input  logic [7:0] led_g,
  input  logic [7:0] led_h,
  input  logic [7:0] seg_sel_out,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] seg_n,
  output logic [7:0] dig_en_n,
  output logic [7:0] bank_sel,
  output logic       frame_start
);

  import seg_scan_pkg::*;

  localparam int       TICK_W  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int       WINDOW  = DIGIT_TICKS - BLANK_TICKS;
  localparam seg_pat_t OFF_LVL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  localparam int unsigned RST_ON = 32'(WINDOW) >> 3;
`else
  localparam int unsigned RST_ON = 32'(WINDOW);
`endif
  localparam slot_state_t RST_STATE = slot_decode(32'd0, 32'(BLANK_TICKS), RST_ON);

  if (BLANK_TICKS >= DIGIT_TICKS || DIGIT_TICKS < 2) begin : g_bad_params
    $error("seg_scan_driver: need DIGIT_TICKS >= 2 and BLANK_TICKS < DIGIT_TICKS");
  end

  logic              slot_wrap;
  logic              frame_wrap;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_next;
  logic [2:0]        idx;

  seg_scan_timer #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .TICK_W      (TICK_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap),
    .tick       (tick),
    .idx        (idx)
  );

  assign tick_next = slot_wrap ? '0 : tick + TICK_W'(1);

  seg_pat_t    led_in [NUM_DIGITS];
  seg_pat_t    snap_reg [NUM_DIGITS];
  seg_pat_t    sel_snap_reg;
  logic        first_reg;
  logic        snap_load;
  slot_state_t state_reg;
  slot_state_t state_next;
  seg_pat_t    seg_reg, seg_next;
  seg_pat_t    dig_reg, dig_next;
  seg_pat_t    bank_reg, bank_next;
  logic        fs_reg, fs_next;
  logic [7:0]  dig_onehot;
  int unsigned on_next;

  assign led_in[0] = led_a;
  assign led_in[1] = led_b;
  assign led_in[2] = led_c;
  assign led_in[3] = led_d;
  assign led_in[4] = led_e;
  assign led_in[5] = led_f;
  assign led_in[6] = led_g;
  assign led_in[7] = led_h;

  // The leftmost digit (idx 0) owns the MSB of the enable bus.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    assign dig_onehot[gi] = (idx == 3'(NUM_DIGITS - 1 - gi));
  end

  // Capture once right after reset and again as the last slot of a frame ends.
  assign snap_load = first_reg | frame_wrap;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] bright_snap_reg;
  logic [2:0] bright_snap_next;

  assign bright_snap_next = snap_load ? bright : bright_snap_reg;
  assign on_next = (32'(WINDOW) * (32'(bright_snap_next) + 32'd1)) >> 3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_snap_reg <= '0;
    end else begin
      bright_snap_reg <= bright_snap_next;
    end
  end
`else
  assign on_next = 32'(WINDOW);
`endif

  function automatic seg_pat_t to_pins(input seg_pat_t v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // state_reg always describes the tick currently held by the timer.
  always_comb begin
    state_next = slot_decode(32'(tick_next), 32'(BLANK_TICKS), on_next);
    seg_next   = OFF_LVL;
    dig_next   = OFF_LVL;
    fs_next    = (tick == '0) && (idx == 3'd0);
    bank_next  = bank_reg;
    case (state_reg)
      SLOT_DRIVE: begin
        seg_next = to_pins(snap_reg[idx]);
        dig_next = to_pins(dig_onehot);
      end
      default: begin
      end
    endcase
    if (fs_next) begin
      bank_next = first_reg ? seg_sel_out : sel_snap_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_reg    <= 1'b1;
      state_reg    <= RST_STATE;
      sel_snap_reg <= '0;
      seg_reg      <= OFF_LVL;
      dig_reg      <= OFF_LVL;
      bank_reg     <= '0;
      fs_reg       <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_reg[i] <= '0;
      end
    end else begin
      first_reg <= 1'b0;
      state_reg <= state_next;
      seg_reg   <= seg_next;
      dig_reg   <= dig_next;
      bank_reg  <= bank_next;
      fs_reg    <= fs_next;
      if (snap_load) begin
        sel_snap_reg <= seg_sel_out;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          snap_reg[i] <= led_in[i];
        end
      end
    end
  end

  assign seg_n       = seg_reg;
  assign dig_en_n    = dig_reg;
  assign bank_sel    = bank_reg;
  assign frame_start = fs_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGIT_TICKS=10, BLANK_TICKS=2, ACTIVE_LOW=1.
// Brightness frames are exercised only when SEG_SCAN_BRIGHTNESS_EN is defined.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] led_a, led_b, led_c, led_d, led_e, led_f, led_g, led_h;
  logic [7:0] seg_sel_out;
  logic [2:0] bright;
  logic [7:0] seg_n, dig_en_n, bank_sel;
  logic       frame_start;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_pat [8];
  logic [7:0] exp_bank;
  int         exp_on;

  seg_scan_driver #(
    .DIGIT_TICKS (10),
    .BLANK_TICKS (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .led_a       (led_a),
    .led_b       (led_b),
    .led_c       (led_c),
    .led_d       (led_d),
    .led_e       (led_e),
    .led_f       (led_f),
    .led_g       (led_g),
    .led_h       (led_h),
    .seg_sel_out (seg_sel_out),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .bright      (bright),
`endif
    .seg_n       (seg_n),
    .dig_en_n    (dig_en_n),
    .bank_sel    (bank_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want run complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks output cycles 0..last of one frame; optionally changes led_a/seg_sel_out after cycle change_at.
  task automatic run_frame(input int fnum, input int last, input int change_at,
                           input logic [7:0] new_a, input logic [7:0] new_sel);
    int         slot;
    int         pos;
    logic       drive;
    logic [7:0] onehot;
    logic [7:0] e_dig;
    logic [7:0] e_seg;
    for (int c = 0; c <= last; c++) begin
      step();
      slot   = c / 10;
      pos    = c % 10;
      drive  = (pos >= 2) && (pos < 2 + exp_on);
      onehot = 8'h80 >> slot;
      e_dig  = drive ? ~onehot : 8'hFF;
      e_seg  = drive ? ~exp_pat[slot] : 8'hFF;
      check_vec($sformatf("f%0d c%0d dig_en_n", fnum, c), {24'd0, dig_en_n}, {24'd0, e_dig});
      check_vec($sformatf("f%0d c%0d seg_n", fnum, c), {24'd0, seg_n}, {24'd0, e_seg});
      check_vec($sformatf("f%0d c%0d frame_start", fnum, c), {31'd0, frame_start}, {31'd0, (c == 0)});
      check_vec($sformatf("f%0d c%0d bank_sel", fnum, c), {24'd0, bank_sel}, {24'd0, exp_bank});
      if (c == change_at) begin
        led_a       = new_a;
        seg_sel_out = new_sel;
      end
    end
    $display("frame %0d: cycles 0..%0d checked, on=%0d, bank=%02h", fnum, last, exp_on, exp_bank);
  endtask

  initial begin
    led_a = 8'h3F; led_b = 8'h00; led_c = 8'h00; led_d = 8'h00;
    led_e = 8'h66; led_f = 8'h00; led_g = 8'h00; led_h = 8'h06;
    seg_sel_out = 8'hA5;
    bright = 3'd7;
    exp_pat = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 8'h06};
    exp_bank = 8'hA5;
    exp_on = 8;

    #1 rst_n = 1'b0;
    step();
    step();
    check_vec("rst seg_n", {24'd0, seg_n}, 32'hFF);
    check_vec("rst dig_en_n", {24'd0, dig_en_n}, 32'hFF);
    check_vec("rst bank_sel", {24'd0, bank_sel}, 32'h00);
    check_vec("rst frame_start", {31'd0, frame_start}, 32'h0);
    $display("reset: outputs held inactive");

    rst_n = 1'b1;
    run_frame(0, 79, -1, 8'h00, 8'h00);
    run_frame(1, 79, 35, 8'h5B, 8'h01);
    exp_pat[0] = 8'h5B;
    exp_bank = 8'h01;
    run_frame(2, 79, -1, 8'h00, 8'h00);

    // Slot 4 is driving at cycle 44; reset lands between clock edges.
    run_frame(3, 44, -1, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check_vec("async rst seg_n", {24'd0, seg_n}, 32'hFF);
    check_vec("async rst dig_en_n", {24'd0, dig_en_n}, 32'hFF);
    check_vec("async rst bank_sel", {24'd0, bank_sel}, 32'h00);
    check_vec("async rst frame_start", {31'd0, frame_start}, 32'h0);
    $display("async reset mid-slot 4: outputs forced inactive");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(4, 79, -1, 8'h00, 8'h00);

`ifdef SEG_SCAN_BRIGHTNESS_EN
    // bright is latched at the frame boundary that already passed, so each change lands one frame later.
    bright = 3'd3;
    run_frame(5, 79, -1, 8'h00, 8'h00);
    exp_on = 4;
    run_frame(6, 79, -1, 8'h00, 8'h00);
    bright = 3'd0;
    run_frame(7, 79, -1, 8'h00, 8'h00);
    exp_on = 1;
    run_frame(8, 79, -1, 8'h00, 8'h00);
    bright = 3'd7;
    run_frame(9, 79, -1, 8'h00, 8'h00);
    exp_on = 8;
    run_frame(10, 79, -1, 8'h00, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
